// File: rtl/mem_lsu.sv
// Load/store unit: CPU-side initiator for the 4 KB byte-enabled data memory.
// Accepts one request per transaction, drives one access cycle, returns an aligned/extended load result or an error.
module mem_lsu #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [9:0]        dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_din,
  output logic              dm_wr,
  input  logic [31:0]       dm_dout
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WADDR_W  = 10;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned PAGE_LSB = 12;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic                cap_we, cap_we_nxt;
  logic                cap_uns, cap_uns_nxt;
  logic [1:0]          cap_size, cap_size_nxt;
  logic [1:0]          cap_lane, cap_lane_nxt;
  logic                rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt;
  logic [WADDR_W-1:0]  dm_addr_nxt;
  logic [BE_W-1:0]     dm_be_nxt;
  logic [DATA_W-1:0]   dm_din_nxt;
  logic                dm_wr_nxt;

  logic                req_err;
  logic [BE_W-1:0]     req_be;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_data;

  assign req_ready = (state == IDLE) && rst;

  // Alignment, size and window legality of the incoming request
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[ADDR_W-1:PAGE_LSB] != BASE_ADDR[ADDR_W-1:PAGE_LSB]) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    req_be = 4'b1111;
    case (req_size)
      SZ_BYTE: req_be = BE_W'(4'b0001 << req_addr[1:0]);
      SZ_HALF: req_be = req_addr[1] ? 4'b1100 : 4'b0011;
      default: req_be = 4'b1111;
    endcase
  end

  // Lane extraction and extension of read data from the captured request
  always_comb begin
    ld_byte = dm_dout[7:0];
    case (cap_lane)
      2'd0:    ld_byte = dm_dout[7:0];
      2'd1:    ld_byte = dm_dout[15:8];
      2'd2:    ld_byte = dm_dout[23:16];
      default: ld_byte = dm_dout[31:24];
    endcase
    ld_half = cap_lane[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (cap_size)
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~cap_uns}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ~cap_uns}}, ld_half};
      default: ld_data = dm_dout;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    cap_we_nxt    = cap_we;
    cap_uns_nxt   = cap_uns;
    cap_size_nxt  = cap_size;
    cap_lane_nxt  = cap_lane;
    rsp_valid_nxt = rsp_valid;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    dm_addr_nxt   = dm_addr;
    dm_be_nxt     = dm_be;
    dm_din_nxt    = dm_din;
    dm_wr_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_err) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            state_nxt    = ACCESS;
            cap_we_nxt   = req_we;
            cap_uns_nxt  = req_unsigned;
            cap_size_nxt = req_size;
            cap_lane_nxt = req_addr[1:0];
            dm_addr_nxt  = req_addr[11:2];
            dm_be_nxt    = req_be;
            dm_din_nxt   = req_wdata;
            dm_wr_nxt    = req_we;
          end
        end
      end
      ACCESS: begin
        state_nxt     = RESP;
        dm_be_nxt     = '0;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = cap_we ? '0 : ld_data;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        dm_be_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_size  <= '0;
      cap_lane  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_din    <= '0;
      dm_wr     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cap_we    <= cap_we_nxt;
      cap_uns   <= cap_uns_nxt;
      cap_size  <= cap_size_nxt;
      cap_lane  <= cap_lane_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      dm_addr   <= dm_addr_nxt;
      dm_be     <= dm_be_nxt;
      dm_din    <= dm_din_nxt;
      dm_wr     <= dm_wr_nxt;
    end
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit driving the CPU side of the 4 KB byte-enabled data memory (dm_4k port: addr[11:2], be, din, DMWr, dout). It accepts one load/store request per transaction from the MEM stage over a valid/ready handshake. It generates word address, byte enables and write strobe, and returns aligned, sign- or zero-extended load data, or an error for misaligned or out-of-range accesses. It is the initiator for the memory's responder port.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base of the data memory window; bits [11:0] are ignored.
ADDR_W, 32, width of the request byte address.

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  zero-extend load (LBU/LHU); ignored for stores and words
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-window or illegal size
dm_addr  output  10  word address to memory
dm_be  output  4  byte enables
dm_din  output  32  write data, unshifted (memory places lanes)
dm_wr  output  1  write strobe (memory writes on negedge)
dm_dout  input  32  combinational read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (rst==0 at posedge): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_addr=0, dm_be=0, dm_din=0, dm_wr=0. req_ready=0 while rst==0.
- req_ready = (state==IDLE) && rst. Handshake fires on req_valid && req_ready at posedge.
- Error check at accept: err if req_size==11; half with addr[0]!=0; word with addr[1:0]!=0; or addr[ADDR_W-1:12]!=BASE_ADDR[ADDR_W-1:12].
- IDLE + fire + err: go to RESP with rsp_err=1, rsp_rdata=0, dm_wr stays 0. Memory is never touched.
- IDLE + fire + ok: go to ACCESS and register dm_addr=addr[11:2], dm_din=req_wdata, dm_wr=req_we.
- dm_be: byte = one-hot at bit addr[1:0] (00→0001, 01→0010, 10→0100, 11→1000); half = addr[1]?1100:0011; word = 1111.
- Loads also drive dm_be (informational; the memory ignores it when dm_wr=0).
- ACCESS lasts exactly one cycle; dm_wr is high for that cycle only. At its end, go to RESP and clear dm_wr/dm_be.
- Load extraction from dm_dout, sampled at end of ACCESS:
  - byte lane = dout[8*a+7 : 8*a] with a=addr[1:0];
  - half = addr[1]?dout[31:16]:dout[15:0];
  - extension is sign unless req_unsigned;
  - word = dout.
  - Stores return rsp_rdata=0.
- RESP: rsp_valid=1, hold rsp_rdata/rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE and clear rsp_valid/rsp_err/rsp_rdata. No new request is accepted in the same cycle.
- Latency: accept at edge N, rsp_valid at edge N+2 (N+1 for errors). Back-to-back throughput is 1 transaction per 3 cycles with rsp_ready tied high.
- Reset mid-operation: synchronous, so a store whose ACCESS cycle coincides with rst==0 still completes its negedge write. From the next posedge, dm_wr=0 and all outputs take reset values. A pending response is discarded.
- Request inputs are don't-care outside the accept cycle; they are captured into internal registers.

Test Plan:
1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → dm_be=1111, dm_wr high for 1 cycle; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
2. SB 0x13 data 0x000000A5, then LB 0x13 → dm_be=1000; LB returns 0xFFFFFFA5, LBU returns 0x000000A5; LW 0x10 returns 0xA5ADBEEF.
3. SH 0x12 data 0x00008001, then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001; SH 0x10 data 0x1234 gives be=0011.
4. LW 0x11, SH 0x21, size=11, and LW 0x1000 with BASE 0 → rsp_err=1, rsp_rdata=0, dm_wr never asserted, rsp_valid 1 cycle after accept; memory content unchanged.
5. Hold rsp_ready=0 for 5 cycles after an LW → rsp_valid and rsp_rdata stable, req_ready=0 throughout; a req_valid pulse during RESP is not accepted.
6. Assert rst=0 during ACCESS of SW 0x20 data 0x55 → the word at 0x20 reads 0x55 afterwards; next cycle dm_wr=0, rsp_valid=0, state IDLE, req_ready=1 once rst=1.
